// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of fetch_sequencer: ROM port, IR handshake, redirect and halt controls.
interface fetch_sequencer_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) ();
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic               ir_ready;
    logic               branch_en;
    logic               branch_rel;
    logic [PC_W-1:0]    branch_target;
    logic               halt_req;
    logic               resume;
    logic               halted;
    logic               call_en;
    logic               ret_en;
    logic               stack_err;

    modport master (
        output pc, ir, ir_pc, ir_valid, halted, stack_err,
        input  rom_data, ir_ready, branch_en, branch_rel, branch_target,
               halt_req, resume, call_en, ret_en
    );

    modport slave (
        input  pc, ir, ir_pc, ir_valid, halted, stack_err,
        output rom_data, ir_ready, branch_en, branch_rel, branch_target,
               halt_req, resume, call_en, ret_en
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC, IR with valid/ready, redirects and halt/resume.
// Define FETCH_SEQ_CALL_EN to build in the STACK_DEPTH-entry return-address stack.
module fetch_sequencer #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC    = 8'h00,
    parameter int              STACK_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {RUN, HALT_PEND, HALT} state_t;

    state_t             state;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_p1;
    logic [PC_W-1:0]    ir_pc_p1;
    logic               vld_p1;
    logic               halted_q;
    logic               stack_err_q;

    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               fetch_ok;

    // Branch offset is two's complement; modular addition gives the sign extension.
    function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] base,
                                                   input logic signed [PC_W-1:0] off);
        return base + $unsigned(off);
    endfunction

    assign fetch_ok = !vld_p1 || bus.ir_ready;

`ifdef FETCH_SEQ_CALL_EN
    localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = SP_W + 1;

    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp_wr;
    logic [CNT_W-1:0] stack_cnt;
    logic             do_push;
    logic             do_pop;
    logic             err_nxt;

    function automatic logic [SP_W-1:0] idx_inc(input logic [SP_W-1:0] idx);
        return (idx == SP_W'(STACK_DEPTH - 1)) ? '0 : idx + SP_W'(1);
    endfunction

    function automatic logic [SP_W-1:0] idx_dec(input logic [SP_W-1:0] idx);
        return (idx == '0) ? SP_W'(STACK_DEPTH - 1) : idx - SP_W'(1);
    endfunction

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = pc_q;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        err_nxt     = 1'b0;
        if (bus.ret_en) begin
            redirect = 1'b1;
            if (stack_cnt == '0) begin
                redirect_pc = RESET_PC;
                err_nxt     = 1'b1;
            end else begin
                redirect_pc = stack_mem[idx_dec(sp_wr)];
                do_pop      = 1'b1;
            end
        end else if (bus.call_en) begin
            redirect    = 1'b1;
            redirect_pc = bus.branch_target;
            do_push     = 1'b1;
            err_nxt     = (stack_cnt == CNT_W'(STACK_DEPTH));
        end else if (bus.branch_en) begin
            redirect    = 1'b1;
            redirect_pc = bus.branch_rel ? rel_target(ir_pc_p1, bus.branch_target)
                                         : bus.branch_target;
        end
    end

    // A full stack keeps its count and overwrites the oldest slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_wr       <= '0;
            stack_cnt   <= '0;
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= err_nxt;
            if (do_push) begin
                sp_wr <= idx_inc(sp_wr);
                if (stack_cnt != CNT_W'(STACK_DEPTH))
                    stack_cnt <= stack_cnt + CNT_W'(1);
            end else if (do_pop) begin
                sp_wr     <= idx_dec(sp_wr);
                stack_cnt <= stack_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            stack_mem[sp_wr] <= ir_pc_p1 + PC_W'(1);
    end
`else
    logic unused_ret;
    localparam int unused_stack_depth = STACK_DEPTH;

    assign unused_ret = bus.ret_en;

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = pc_q;
        if (bus.call_en) begin
            redirect    = 1'b1;
            redirect_pc = bus.branch_target;
        end else if (bus.branch_en) begin
            redirect    = 1'b1;
            redirect_pc = bus.branch_rel ? rel_target(ir_pc_p1, bus.branch_target)
                                         : bus.branch_target;
        end
    end

    assign stack_err_q = 1'b0;
`endif

    // Redirects win in every state; one arriving outside plain RUN (or with halt_req) lands in HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            ir_p1    <= '0;
            ir_pc_p1 <= '0;
            vld_p1   <= 1'b0;
            halted_q <= 1'b0;
        end else if (redirect) begin
            pc_q   <= redirect_pc;
            vld_p1 <= 1'b0;
            if (state != RUN || bus.halt_req) begin
                state    <= HALT;
                halted_q <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt_req) begin
                        if (vld_p1 && bus.ir_ready)
                            vld_p1 <= 1'b0;
                        if (vld_p1) begin
                            state <= HALT_PEND;
                        end else begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end
                    end else if (fetch_ok) begin
                        ir_p1    <= bus.rom_data;
                        ir_pc_p1 <= pc_q;
                        vld_p1   <= 1'b1;
                        pc_q     <= pc_q + PC_W'(1);
                    end
                end
                HALT_PEND: begin
                    if (!vld_p1) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.ir_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                HALT: begin
                    if (bus.resume && !bus.halt_req) begin
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ir        = ir_p1;
    assign bus.ir_pc     = ir_pc_p1;
    assign bus.ir_valid  = vld_p1;
    assign bus.halted    = halted_q;
    assign bus.stack_err = stack_err_q;
endmodule
